// File: rtl/seg_scan_ctrl.sv
// Multi-channel 7-segment display scanner: rotates (or manually selects) an input
// channel, converts it to BCD with a sequential shift-and-add-3 engine and multiplexes the digits.
module seg_scan_ctrl #(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 8,
    parameter int NUM_DIG  = 4,
    parameter int SCAN_DIV = 16384,
    parameter int DWELL    = 2**23,
    parameter int GAP      = 2**21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     mode,
    input  logic [2:0]               sel,
    input  logic                     lz_blank,
    output logic [6:0]               seg,
    output logic [7:0]               an,
    output logic [2:0]               cur_ch,
    output logic                     conv_busy
);
    // Eight BCD digits cover the widest input (2^26-1 has 8 decimal digits).
    localparam int          BCD_W      = 32;
    localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP - 1);
    localparam logic [31:0] SCAN_LAST  = 32'(SCAN_DIV - 1);
    localparam logic [2:0]  CH_LAST    = 3'(NUM_CH - 1);
    localparam logic [2:0]  DIG_LAST   = 3'(NUM_DIG - 1);
    localparam logic [4:0]  BIT_LAST   = 5'(DATA_W - 1);
    localparam logic [7:0]  HIGH_MASK  = 8'(~((1 << NUM_DIG) - 1));

    typedef enum logic {CH_SHOW, CH_GAP} ch_state_t;
    typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_LATCH} cv_state_t;

    ch_state_t               ch_state_reg, ch_state_next;
    logic [31:0]             ch_cnt_reg, ch_cnt_next;
    logic [2:0]              cur_ch_reg, cur_ch_next, sel_clamped;
    cv_state_t               cv_state_reg, cv_state_next;
    logic [DATA_W-1:0]       bin_reg, bin_next;
    logic [BCD_W-1:0]        bcd_reg, bcd_next, bcd_adj;
    logic [2:0]              tag_reg, tag_next;
    logic [4:0]              bit_cnt_reg, bit_cnt_next;
    logic [BCD_W-1:0]        disp_reg, disp_next;
    logic                    ovf_reg, ovf_next, valid_reg, valid_next;
    logic [31:0]             scan_cnt_reg, scan_cnt_next;
    logic [2:0]              dig_reg, dig_next;
    logic [6:0]              seg_reg, seg_next;
    logic [7:0]              an_reg, an_next;
    logic [DATA_W-1:0]       ch_arr [NUM_CH];
    logic [7:0]              bcd_nz, disp_nz;
    logic [BCD_W+DATA_W-1:0] shift_vec;
    logic [3:0]              cur_digit;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_arr[gi] = ch_data[gi*DATA_W +: DATA_W];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_bcd
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                                     : bcd_reg[gi*4 +: 4];
            assign bcd_nz[gi]  = |bcd_reg[gi*4 +: 4];
            assign disp_nz[gi] = |disp_reg[gi*4 +: 4];
        end
    endgenerate

    assign sel_clamped = ({1'b0, sel} >= 4'(NUM_CH)) ? CH_LAST : sel;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Manual mode parks the FSM in SHOW with a cleared dwell count, so returning
    // to auto mode naturally restarts a full dwell on the current channel.
    always_comb begin
        ch_state_next = ch_state_reg;
        ch_cnt_next   = ch_cnt_reg + 32'd1;
        cur_ch_next   = cur_ch_reg;
        if (mode) begin
            ch_state_next = CH_SHOW;
            ch_cnt_next   = '0;
            cur_ch_next   = sel_clamped;
        end else begin
            case (ch_state_reg)
                CH_SHOW: if (ch_cnt_reg == DWELL_LAST) begin
                    ch_state_next = CH_GAP;
                    ch_cnt_next   = '0;
                end
                CH_GAP: if (ch_cnt_reg == GAP_LAST) begin
                    ch_state_next = CH_SHOW;
                    ch_cnt_next   = '0;
                    cur_ch_next   = (cur_ch_reg == CH_LAST) ? 3'd0 : cur_ch_reg + 3'd1;
                end
                default: ch_state_next = CH_SHOW;
            endcase
        end
    end

    always_comb begin
        cv_state_next = cv_state_reg;
        bin_next      = bin_reg;
        bcd_next      = bcd_reg;
        tag_next      = tag_reg;
        bit_cnt_next  = bit_cnt_reg;
        disp_next     = disp_reg;
        ovf_next      = ovf_reg;
        valid_next    = valid_reg;
        shift_vec     = {bcd_adj, bin_reg} << 1;
        case (cv_state_reg)
            CV_IDLE: begin
                bin_next      = ch_arr[cur_ch_reg];
                bcd_next      = '0;
                tag_next      = cur_ch_reg;
                bit_cnt_next  = '0;
                cv_state_next = CV_SHIFT;
            end
            CV_SHIFT: begin
                bcd_next = shift_vec[BCD_W+DATA_W-1 -: BCD_W];
                bin_next = shift_vec[DATA_W-1:0];
                if (bit_cnt_reg == BIT_LAST) cv_state_next = CV_LATCH;
                else                         bit_cnt_next  = bit_cnt_reg + 5'd1;
            end
            CV_LATCH: begin
                // A result for a channel no longer shown is stale; drop it.
                if (tag_reg == cur_ch_reg) begin
                    disp_next  = bcd_reg;
                    ovf_next   = |(bcd_nz & HIGH_MASK);
                    valid_next = 1'b1;
                end
                cv_state_next = CV_IDLE;
            end
            default: cv_state_next = CV_IDLE;
        endcase
    end

    always_comb begin
        scan_cnt_next = scan_cnt_reg + 32'd1;
        dig_next      = dig_reg;
        if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_next = '0;
            dig_next      = (dig_reg == DIG_LAST) ? 3'd0 : dig_reg + 3'd1;
        end
    end

    always_comb begin
        seg_next  = 7'h7F;
        an_next   = 8'hFF;
        cur_digit = disp_reg[{dig_reg, 2'b00} +: 4];
        if (ch_state_reg == CH_SHOW && valid_reg) begin
            an_next = ~(8'd1 << dig_reg);
            if (ovf_reg)
                seg_next = 7'b0111111;
            else if (lz_blank && dig_reg != 3'd0 && (disp_nz >> dig_reg) == 8'd0)
                seg_next = 7'h7F;
            else
                seg_next = seg_decode(cur_digit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_state_reg <= CH_SHOW;
            ch_cnt_reg   <= '0;
            cur_ch_reg   <= '0;
            cv_state_reg <= CV_IDLE;
            bin_reg      <= '0;
            bcd_reg      <= '0;
            tag_reg      <= '0;
            bit_cnt_reg  <= '0;
            disp_reg     <= '0;
            ovf_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            scan_cnt_reg <= '0;
            dig_reg      <= '0;
            seg_reg      <= 7'h7F;
            an_reg       <= 8'hFF;
        end else begin
            ch_state_reg <= ch_state_next;
            ch_cnt_reg   <= ch_cnt_next;
            cur_ch_reg   <= cur_ch_next;
            cv_state_reg <= cv_state_next;
            bin_reg      <= bin_next;
            bcd_reg      <= bcd_next;
            tag_reg      <= tag_next;
            bit_cnt_reg  <= bit_cnt_next;
            disp_reg     <= disp_next;
            ovf_reg      <= ovf_next;
            valid_reg    <= valid_next;
            scan_cnt_reg <= scan_cnt_next;
            dig_reg      <= dig_next;
            seg_reg      <= seg_next;
            an_reg       <= an_next;
        end
    end

    assign seg       = seg_reg;
    assign an        = an_reg;
    assign cur_ch    = cur_ch_reg;
    assign conv_busy = (cv_state_reg != CV_IDLE);
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: vector table, hand sequences for timing corners,
// and randomized manual-mode trials against an arithmetic display model.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
    localparam int NUM_CH = 3, DATA_W = 8, SCAN_DIV = 2, DWELL = 40, GAP = 10;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic                     mode = 1'b0;
    logic [2:0]               sel = 3'd0;
    logic                     lz_blank = 1'b0;
    logic [6:0]               seg, seg2;
    logic [7:0]               an, an2;
    logic [2:0]               cur_ch, cur_ch2;
    logic                     conv_busy, conv_busy2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    seg_scan_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .NUM_DIG(4), .SCAN_DIV(SCAN_DIV),
                    .DWELL(DWELL), .GAP(GAP)) u_dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .mode(mode), .sel(sel), .lz_blank(lz_blank),
        .seg(seg), .an(an), .cur_ch(cur_ch), .conv_busy(conv_busy));

    seg_scan_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .NUM_DIG(2), .SCAN_DIV(SCAN_DIV),
                    .DWELL(DWELL), .GAP(GAP)) u_dut2 (
        .clk(clk), .rst(rst), .ch_data(ch_data), .mode(mode), .sel(sel), .lz_blank(lz_blank),
        .seg(seg2), .an(an2), .cur_ch(cur_ch2), .conv_busy(conv_busy2));

    always #5 clk = ~clk;

    // Rising edges since reset release.
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    typedef struct {
        int unsigned val;
        bit          lz;
        int          dig;
        logic [7:0]  an;
        logic [6:0]  seg;
    } vec_t;
    vec_t vecs[12];

    function automatic logic [6:0] dec(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // {an, seg} for showing value v on digit d of an ndig-digit display.
    function automatic logic [14:0] model(input int unsigned v, input int d, input bit lz, input int ndig);
        int unsigned p   = 1;
        int unsigned lim = 1;
        logic [7:0]  a;
        logic [6:0]  s;
        for (int i = 0; i < d; i++)    p   = p * 10;
        for (int i = 0; i < ndig; i++) lim = lim * 10;
        a = ~(8'd1 << d);
        if (v >= lim)                 s = 7'b0111111;
        else if (lz && d > 0 && v < p) s = 7'h7F;
        else                          s = dec(int'((v / p) % 10));
        return {a, s};
    endfunction

    function automatic int dig_of(input int n, input int ndig);
        return ((n - 1) / SCAN_DIV) % ndig;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_cur_ch", 32'(cur_ch), 32'd0);
        chk("rst_busy", 32'(conv_busy), 32'd0);
        rst = 1'b0;
    endtask

    // First conversion: busy for 9 of every 10 cycles, display blank until edge 11.
    task automatic startup(input int unsigned v, input bit lz);
        int n;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n = cyc;
            chk("startup_busy", 32'(conv_busy), 32'((n % 10) != 0));
            if (n <= 10) chk("startup_blank", 32'({an, seg}), 32'({8'hFF, 7'h7F}));
            else         chk("startup_show", 32'({an, seg}), 32'(model(v, dig_of(n, 4), lz, 4)));
        end
        $display("startup value=%0d lz=%0d checked", v, lz);
    endtask

    initial begin
        int n, p, c, guard, n1;
        int unsigned auto_vals[3];
        int unsigned prev_val;
        bit prev_lz;

        vecs[0]  = '{123, 1'b1, 0, 8'hFE, 7'b0110000};
        vecs[1]  = '{123, 1'b1, 1, 8'hFD, 7'b0100100};
        vecs[2]  = '{123, 1'b1, 2, 8'hFB, 7'b1111001};
        vecs[3]  = '{123, 1'b1, 3, 8'hF7, 7'b1111111};
        vecs[4]  = '{7,   1'b0, 0, 8'hFE, 7'b1111000};
        vecs[5]  = '{7,   1'b0, 1, 8'hFD, 7'b1000000};
        vecs[6]  = '{7,   1'b0, 2, 8'hFB, 7'b1000000};
        vecs[7]  = '{7,   1'b0, 3, 8'hF7, 7'b1000000};
        vecs[8]  = '{7,   1'b1, 1, 8'hFD, 7'b1111111};
        vecs[9]  = '{0,   1'b1, 0, 8'hFE, 7'b1000000};
        vecs[10] = '{105, 1'b1, 1, 8'hFD, 7'b1000000};
        vecs[11] = '{105, 1'b1, 2, 8'hFB, 7'b1111001};

        // First capture and display latency after reset.
        mode = 1'b0; lz_blank = 1'b0;
        ch_data = {8'd0, 8'd0, 8'd123};
        do_reset();
        startup(123, 1'b0);

        // Auto rotation: 40 cycles show, 10 cycles gap, channels 0->1->2->0.
        auto_vals[0] = 10; auto_vals[1] = 20; auto_vals[2] = 30;
        ch_data = {8'd30, 8'd20, 8'd10};
        do_reset();
        for (int i = 0; i < 160; i++) begin
            tick();
            n = cyc;
            p = (n - 1) % (DWELL + GAP);
            c = ((n - 1) / (DWELL + GAP)) % NUM_CH;
            chk("auto_cur_ch", 32'(cur_ch), 32'((n / (DWELL + GAP)) % NUM_CH));
            if (p >= DWELL)
                chk("auto_gap", 32'({an, seg}), 32'({8'hFF, 7'h7F}));
            else if (p >= 10)
                chk("auto_show", 32'({an, seg}), 32'(model(auto_vals[c], dig_of(n, 4), 1'b0, 4)));
        end
        $display("auto rotation 160 cycles checked");

        // Vector table in manual mode on channel 0.
        mode = 1'b1; sel = 3'd0;
        prev_val = 32'hFFFF_FFFF; prev_lz = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].val != prev_val || vecs[i].lz != prev_lz) begin
                ch_data[7:0] = vecs[i].val[7:0];
                lz_blank     = vecs[i].lz;
                prev_val     = vecs[i].val;
                prev_lz      = vecs[i].lz;
                repeat (22) tick();
            end
            guard = 0;
            while (dig_of(cyc, 4) != vecs[i].dig && guard < 16) begin
                tick();
                guard++;
            end
            chk("vec_dig_wait", 32'(guard < 16), 32'd1);
            chk("vec_out", 32'({an, seg}), 32'({vecs[i].an, vecs[i].seg}));
            $display("vec %0d val=%0d lz=%0d dig=%0d an=%h seg=%b", i, vecs[i].val, vecs[i].lz,
                     vecs[i].dig, an, seg);
        end

        // Out-of-range select clamps; 255 overflows a two-digit display.
        sel = 3'd5; lz_blank = 1'b0;
        ch_data = {8'd255, 8'd77, 8'd66};
        tick();
        chk("clamp_cur_ch", 32'(cur_ch), 32'd2);
        repeat (21) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ovf_seg", 32'(seg2), 32'b0111111);
            chk("ovf_an", 32'(an2), 32'(model(255, dig_of(cyc, 2), 1'b0, 2) >> 7));
            chk("nonovf_out", 32'({an, seg}), 32'(model(255, dig_of(cyc, 4), 1'b0, 4)));
        end
        $display("clamp/overflow sel=5 value=255 checked");

        // Randomized manual-mode trials against the model on both display widths.
        for (int t = 0; t < 12; t++) begin
            int unsigned vals[3];
            int s, cs;
            for (int k = 0; k < 3; k++) begin
                vals[k] = $urandom_range(0, 255);
                ch_data[k*8 +: 8] = 8'(vals[k]);
            end
            s        = int'($urandom_range(0, 7));
            sel      = 3'(s);
            lz_blank = 1'($urandom_range(0, 1));
            cs       = (s >= NUM_CH) ? NUM_CH - 1 : s;
            tick();
            chk("rand_cur_ch", 32'(cur_ch), 32'(cs));
            chk("rand_cur_ch2", 32'(cur_ch2), 32'(cs));
            repeat (21) tick();
            for (int k = 0; k < 8; k++) begin
                tick();
                chk("rand_out4", 32'({an, seg}), 32'(model(vals[cs], dig_of(cyc, 4), lz_blank, 4)));
                chk("rand_out2", 32'({an2, seg2}), 32'(model(vals[cs], dig_of(cyc, 2), lz_blank, 2)));
            end
            $display("trial %0d sel=%0d ch=%0d value=%0d lz=%0d", t, s, cs, vals[cs], lz_blank);
        end

        // Channel switch between capture and latch: that result is discarded.
        sel = 3'd0; lz_blank = 1'b0;
        ch_data = {8'd0, 8'd222, 8'd111};
        repeat (25) tick();
        guard = 0;
        while (cyc % 10 != 0 && guard < 12) begin
            tick();
            guard++;
        end
        chk("discard_align_wait", 32'(guard < 12), 32'd1);
        ch_data[7:0] = 8'd55;
        tick();
        sel = 3'd1;
        n1  = cyc;
        for (int k = 0; k < 26; k++) begin
            tick();
            n = cyc;
            if (k == 0) chk("discard_cur_ch", 32'(cur_ch), 32'd1);
            if (n <= n1 + 19) chk("discard_hold", 32'({an, seg}), 32'(model(111, dig_of(n, 4), 1'b0, 4)));
            else              chk("discard_next", 32'({an, seg}), 32'(model(222, dig_of(n, 4), 1'b0, 4)));
        end
        $display("tag-mismatch discard sequence checked");

        // Reset in the middle of a shift: immediate reset outputs, then a clean restart.
        sel = 3'd2; lz_blank = 1'b1;
        ch_data = {8'd42, 8'd0, 8'd0};
        repeat (25) tick();
        guard = 0;
        while (cyc % 10 != 4 && guard < 12) begin
            tick();
            guard++;
        end
        chk("pre_rst_busy", 32'(conv_busy), 32'd1);
        chk("pre_rst_cur_ch", 32'(cur_ch), 32'd2);
        rst = 1'b1;
        #1;
        chk("async_rst_seg", 32'(seg), 32'h7F);
        chk("async_rst_an", 32'(an), 32'hFF);
        chk("async_rst_cur_ch", 32'(cur_ch), 32'd0);
        chk("async_rst_busy", 32'(conv_busy), 32'd0);
        sel = 3'd0;
        ch_data = {8'd0, 8'd0, 8'd42};
        @(negedge clk);
        rst = 1'b0;
        startup(42, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of input channels, 1..8.
REQ-002 SHALL have parameter DATA_W, default 8: bits per channel, 4..26.
REQ-003 SHALL have parameter NUM_DIG, default 4: digits driven, 1..8.
REQ-004 SHALL have parameter SCAN_DIV, default 16384: clk cycles per digit slot.
REQ-005 SHALL have parameters DWELL, default 2^23, and GAP, default 2^21: clk cycles of channel show and of blank gap.
REQ-006 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port ch_data  in  NUM_CH*DATA_W  channel k value at [k*DATA_W +: DATA_W], unsigned.
REQ-009 SHALL have port mode  in  1  0 = auto-rotate channels, 1 = manual select.
REQ-010 SHALL have port sel  in  3  manual channel index.
REQ-011 SHALL have port lz_blank  in  1  1 = blank leading zeros.
REQ-012 SHALL have port seg  out  7  {g,f,e,d,c,b,a}, active-low.
REQ-013 SHALL have port an  out  8  digit enables, active-low, bit i = digit i.
REQ-014 SHALL have ports cur_ch  out  3  channel shown, and conv_busy  out  1  BCD conversion in progress.

Function
REQ-015 Channel FSM SHALL have states SHOW and GAP; auto mode: SHOW DWELL cycles, then GAP GAP cycles, then SHOW next channel, NUM_CH-1 wraps to 0.
REQ-016 Manual mode: FSM SHALL stay in SHOW; cur_ch = sel, with sel >= NUM_CH clamped to NUM_CH-1; change takes effect the cycle after sel changes.
REQ-017 mode 1->0 SHALL restart SHOW on cur_ch with dwell counter cleared; mode 0->1 during GAP SHALL go to SHOW immediately.
REQ-018 Converter FSM SHALL have states IDLE, SHIFT, LATCH; from IDLE it captures ch_data of cur_ch and tags cur_ch, runs DATA_W shift-and-add-3 cycles in SHIFT, then one LATCH cycle.
REQ-019 Converter SHALL restart from IDLE the cycle after LATCH (free-running); capture-to-display-register latency = DATA_W+2 cycles.
REQ-020 conv_busy SHALL be 1 in SHIFT and LATCH, 0 in IDLE.
REQ-021 If cur_ch differs from the tag at LATCH, result SHALL be discarded and display register unchanged.
REQ-022 Display register SHALL hold NUM_DIG BCD digits plus valid flag; valid set on first accepted LATCH.
REQ-023 Value >= 10^NUM_DIG SHALL set overflow: every enabled digit shows '-' (seg 7'b0111111).
REQ-024 Digit counter SHALL advance 0..NUM_DIG-1 every SCAN_DIV cycles and wrap to 0; runs in all states.
REQ-025 In SHOW with valid=1: an = bit d low only (d = digit counter), bits >= NUM_DIG always 1; seg = decode of digit d (0=1000000,1=1111001,2=0100100,3=0110000,4=0011001,5=0010010,6=0000010,7=1111000,8=0000000,9=0010000).
REQ-026 lz_blank=1: digits above most significant nonzero digit SHALL show seg 7'h7F with an still driven; digit 0 always shown.
REQ-027 In GAP, or valid=0: an = 8'hFF, seg = 7'h7F.
REQ-028 seg and an SHALL be registered, updating one cycle after the digit counter or FSM state changes.

Reset
REQ-029 rst=1 SHALL immediately force seg=7'h7F, an=8'hFF, cur_ch=0, conv_busy=0, valid=0, all counters 0, channel FSM SHOW, converter IDLE.
REQ-030 rst asserted mid-conversion SHALL abort it; no partial result latched.

Verification (NUM_CH=3, DATA_W=8, NUM_DIG=4, SCAN_DIV=2, DWELL=40, GAP=10 unless stated)
REQ-031 Release rst, ch0=123 -> seg=7F, an=FF until display register update 10 cycles after first capture; conv_busy pulses 9 cycles per conversion.
REQ-032 ch0=123, lz_blank=1, mode=1, sel=0 -> repeating (an,seg): (FE,0110000),(FD,0100100),(FB,1111001),(F7,1111111).
REQ-033 ch0=7, lz_blank=0 -> digits 7,0,0,0: seg 1111000 then 1000000 x3.
REQ-034 mode=0, ch=10/20/30 -> cur_ch 0->1->2->0, 40 cycles shown each, an=FF for 10 gap cycles between.
REQ-035 mode=1, sel=5 -> cur_ch=2; NUM_DIG=2, ch2=255 -> both digits seg 0111111.
REQ-036 rst pulse mid-SHIFT -> outputs at reset values same cycle, no display update until a full new conversion.
